button_bank: RTL and testbench



---
 rtl/button_bank.sv | 149 ++++++++++++++
 tb/tb_button_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: per-channel synchroniser, debounce,
// press/release pulses, long-press detection and optional auto-repeat.

module button_lane #(
  parameter int DEB_W      = 18,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_W     = 25,
  parameter int LONG_CYC   = 25_000_000,
  parameter int REP_CYC    = 5_000_000,
  parameter int REPEAT_EN  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic long_active
);
  localparam int THRESH = 1 << (DEB_W - 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam logic [DEB_W-1:0]  THR_M1  = DEB_W'(THRESH - 1);
  localparam logic [LONG_W-1:0] LONG_M1 = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] REP_M1  = LONG_W'(REP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [2:0]        sync;
  logic              p;
  logic [DEB_W-1:0]  cnt;
  logic              flip, rise, fall;
  state_t            state, state_nxt;
  logic [LONG_W-1:0] timer, timer_nxt;
  logic              long_nxt, rep_nxt;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {3{REL_LVL}};
    else        sync <= {sync[1:0], key};

  assign p    = sync[2] ^ REL_LVL;
  assign flip = (p != pressed) && (cnt == THR_M1);
  assign rise = flip && p;
  assign fall = flip && !p;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pressed       <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (p == pressed) cnt <= '0;
      else if (flip) begin
        pressed <= p;
        cnt     <= '0;
      end else cnt <= cnt + 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= rep_nxt;
    end

  // A release edge overrides any pulse that would land on the same clock.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    if (fall) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE:
          if (rise) begin
            state_nxt = HELD;
            timer_nxt = '0;
          end
        HELD:
          if (timer == LONG_M1) begin
            long_nxt  = 1'b1;
            state_nxt = REPEAT;
            timer_nxt = '0;
          end else timer_nxt = timer + 1'b1;
        REPEAT:
          if (timer == REP_M1) begin
            timer_nxt = '0;
            rep_nxt   = (REPEAT_EN != 0);
          end else timer_nxt = timer + 1'b1;
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_comb long_active = (state == REPEAT);
endmodule

// release/repeat are language keywords, hence the _pulse suffix on those ports.
module button_bank #(
  parameter int N          = 4,
  parameter int DEB_W      = 18,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_W     = 25,
  parameter int LONG_CYC   = 25_000_000,
  parameter int REP_CYC    = 5_000_000,
  parameter int REPEAT_EN  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_pulse,
  output logic [N-1:0] long_active,
  output logic         any_press
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    button_lane #(
      .DEB_W(DEB_W), .ACTIVE_LOW(ACTIVE_LOW), .LONG_W(LONG_W),
      .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(REPEAT_EN)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .key(key[i]),
      .pressed(pressed[i]), .press(press[i]), .release_pulse(release_pulse[i]),
      .long_press(long_press[i]), .repeat_pulse(repeat_pulse[i]),
      .long_active(long_active[i])
    );
  end

  assign any_press = |press;
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: N=2, THRESH=8, LONG_CYC=20, REP_CYC=6, active-low keys.

module tb_button_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key = 2'b11;

  logic [1:0] pressed, press, rel, lp, rep, la;
  logic       anyp;
  logic [1:0] pressed1, press1, rel1, lp1, rep1, la1;
  logic       anyp1;

  int checks = 0;
  int failures = 0;
  int n_press0 = 0, n_press1 = 0, n_any = 0, n_rel0 = 0, n_rep0 = 0, n_rep1 = 0, n_lp1 = 0;
  int b_press0, b_rel0, b_any;

  always #5 clk = ~clk;

  button_bank #(.N(2), .DEB_W(4), .ACTIVE_LOW(1), .LONG_W(8), .LONG_CYC(20),
                .REP_CYC(6), .REPEAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .pressed(pressed), .press(press),
    .release_pulse(rel), .long_press(lp), .repeat_pulse(rep), .long_active(la),
    .any_press(anyp));

  button_bank #(.N(2), .DEB_W(4), .ACTIVE_LOW(1), .LONG_W(8), .LONG_CYC(20),
                .REP_CYC(6), .REPEAT_EN(0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .key(key), .pressed(pressed1), .press(press1),
    .release_pulse(rel1), .long_press(lp1), .repeat_pulse(rep1), .long_active(la1),
    .any_press(anyp1));

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    n_press0 += int'(press[0]);
    n_press1 += int'(press[1]);
    n_any    += int'(anyp);
    n_rel0   += int'(rel[0]);
    n_rep0   += int'(rep[0]);
    n_rep1   += int'(rep1[0]);
    n_lp1    += int'(lp1[0]);
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    adv(3);
    check("rst_pressed", {30'd0, pressed}, 32'd0);
    check("rst_pulses", {20'd0, press, rel, lp, rep, la, anyp, 1'b0}, 32'd0);
    check("rst_norep", {20'd0, pressed1, press1, rel1, lp1, rep1, anyp1}, 32'd0);
    rst_n = 1'b1;
    adv(3);
    check("idle_pressed", {30'd0, pressed}, 32'd0);

    // Clean press on key0: pulse only in the cycle after e10
    key = 2'b10;
    adv(10);
    check("press_e9", {30'd0, press}, 32'd0);
    adv(1);
    check("press_e10", {30'd0, press}, 32'd1);
    check("any_e10", {31'd0, anyp}, 32'd1);
    check("pressed_e10", {30'd0, pressed}, 32'd1);
    adv(1);
    check("press_e11", {30'd0, press}, 32'd0);
    check("any_e11", {31'd0, anyp}, 32'd0);
    check("pressed_e11", {30'd0, pressed}, 32'd1);
    check("ch1_silent", n_press1, 32'd0);

    // Long press 20 cycles after press, then repeats every 6
    adv(18);
    check("lp_e29", {28'd0, lp, la}, 32'd0);
    adv(1);
    check("lp_e30", {31'd0, lp[0]}, 32'd1);
    check("la_e30", {31'd0, la[0]}, 32'd1);
    check("lp_norep_e30", {31'd0, lp1[0]}, 32'd1);
    adv(1);
    check("lp_e31", {31'd0, lp[0]}, 32'd0);
    check("la_e31", {31'd0, la[0]}, 32'd1);
    adv(4);
    check("rep_e35", {31'd0, rep[0]}, 32'd0);
    adv(1);
    check("rep_e36", {31'd0, rep[0]}, 32'd1);
    check("rep_norep_e36", {31'd0, rep1[0]}, 32'd0);
    adv(6);
    check("rep_e42", {31'd0, rep[0]}, 32'd1);
    adv(6);
    check("rep_e48", {31'd0, rep[0]}, 32'd1);
    adv(1);

    // Release so that the release edge coincides with the next repeat threshold
    key = 2'b11;
    adv(5);
    check("rep_e54", {31'd0, rep[0]}, 32'd1);
    adv(5);
    check("rel_f9", {31'd0, rel[0]}, 32'd0);
    check("la_f9", {31'd0, la[0]}, 32'd1);
    adv(1);
    check("rel_f10", {31'd0, rel[0]}, 32'd1);
    check("la_f10", {31'd0, la[0]}, 32'd0);
    check("pressed_f10", {31'd0, pressed[0]}, 32'd0);
    check("rep_dropped", {31'd0, rep[0]}, 32'd0);
    adv(10);
    check("rep_total", n_rep0, 32'd4);
    check("rel_total", n_rel0, 32'd1);
    check("norep_rep_total", n_rep1, 32'd0);
    check("norep_lp_total", n_lp1, 32'd1);

    // Bouncing key: toggles every 5 cycles give nothing, then a clean press
    b_press0 = n_press0;
    b_rel0 = n_rel0;
    for (int i = 0; i < 8; i++) begin
      key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      adv(5);
    end
    key[0] = 1'b0;
    adv(10);
    check("bounce_no_press", n_press0 - b_press0, 32'd0);
    check("bounce_no_rel", n_rel0 - b_rel0, 32'd0);
    check("bounce_pressed", {31'd0, pressed[0]}, 32'd0);
    adv(1);
    check("bounce_press_e10", {31'd0, press[0]}, 32'd1);

    // Simultaneous press on both channels
    key = 2'b11;
    adv(15);
    check("both_released", {30'd0, pressed}, 32'd0);
    b_any = n_any;
    key = 2'b00;
    adv(10);
    check("both_e9", {30'd0, press}, 32'd0);
    adv(1);
    check("both_e10", {30'd0, press}, 32'd3);
    check("both_any_e10", {31'd0, anyp}, 32'd1);
    adv(1);
    check("both_any_e11", {31'd0, anyp}, 32'd0);
    check("both_any_count", n_any - b_any, 32'd1);

    // Asynchronous reset while held: immediate clear, no release pulse
    adv(5);
    b_rel0 = n_rel0;
    rst_n = 1'b0;
    #1;
    check("arst_pressed", {30'd0, pressed}, 32'd0);
    check("arst_outs", {21'd0, press, rel, lp, rep, la, anyp}, 32'd0);
    adv(2);
    rst_n = 1'b1;
    adv(10);
    check("arst_e9", {31'd0, press[0]}, 32'd0);
    adv(1);
    check("arst_e10", {31'd0, press[0]}, 32'd1);
    check("arst_no_rel", n_rel0 - b_rel0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
